// File: rtl/sram_byte_bridge_pkg.sv
// Shared types and constants for the 65xx-to-SRAM byte bridge.
// Holds the FSM state encoding, the lane selectors and the timeout sizing helper.
package sram_bridge_pkg;

    localparam int unsigned DEF_CPU_AW      = 19;
    localparam int unsigned DEF_MEM_AW      = 18;
    localparam int unsigned DEF_TIMEOUT_CYC = 15;

    function automatic int unsigned tmr_width(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

    localparam int unsigned TMR_W = tmr_width(DEF_TIMEOUT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_FETCH,
        ST_WR_STORE
    } state_t;

    localparam logic       LANE_LO     = 1'b0;
    localparam logic       LANE_HI     = 1'b1;
    localparam logic [7:0] RD_ERR_BYTE = 8'hFF;

endpackage

// File: rtl/sram_byte_bridge_if.sv
// CPU-side and SRAM-controller-side signals of the byte bridge.
// slave = bridge view, master = the view of whatever drives the CPU bus and SRAM controller.
interface sram_byte_bridge_if
    import sram_bridge_pkg::*;
#(
    parameter int unsigned CPU_AW = DEF_CPU_AW,
    parameter int unsigned MEM_AW = DEF_MEM_AW
) ();
    logic              cpu_stb;
    logic [CPU_AW-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_rd;
    logic              cpu_wr;
    logic [7:0]        cpu_rdata;
    logic              cpu_ready;
    logic [MEM_AW-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [15:0]       mem_rdata;
    logic              mem_ready;
    logic              err;

    modport slave (
        input  cpu_stb, cpu_addr, cpu_wdata, cpu_rd, cpu_wr, mem_rdata, mem_ready,
        output cpu_rdata, cpu_ready, mem_addr, mem_wdata, mem_rd, mem_wr, err
    );

    modport master (
        output cpu_stb, cpu_addr, cpu_wdata, cpu_rd, cpu_wr, mem_rdata, mem_ready,
        input  cpu_rdata, cpu_ready, mem_addr, mem_wdata, mem_rd, mem_wr, err
    );
endinterface

// File: rtl/sram_byte_bridge_timer.sv
// Clearable saturating wait counter for the bridge; o_expired marks the
// LIMIT-th consecutive waiting cycle.
module sram_req_timer
    import sram_bridge_pkg::*;
#(
    parameter int unsigned LIMIT = DEF_TIMEOUT_CYC,
    parameter int unsigned W     = TMR_W
) (
    input  logic CLK0,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge CLK0) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_expired = (r_cnt == W'(LIMIT - 1));
endmodule

// File: rtl/sram_byte_bridge.sv
// 8-bit CPU bus to 16-bit SRAM bridge with read-modify-write byte stores and request timeout.
// Optional one-word cache: define SRAM_BRIDGE_WORD_CACHE_EN.
module sram_byte_bridge
    import sram_bridge_pkg::*;
#(
    parameter int unsigned CPU_AW      = DEF_CPU_AW,
    parameter int unsigned MEM_AW      = DEF_MEM_AW,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input logic               CLK0,
    input logic               reset_n,
    sram_byte_bridge_if.slave bus
);
    state_t            r_state, w_state_nxt;
    logic              r_cpu_ready, w_cpu_ready_nxt;
    logic [7:0]        r_cpu_rdata, w_cpu_rdata_nxt;
    logic              r_mem_rd, w_mem_rd_nxt;
    logic              r_mem_wr, w_mem_wr_nxt;
    logic [MEM_AW-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [15:0]       r_mem_wdata, w_mem_wdata_nxt;
    logic              r_err, w_err_nxt;
    logic              r_lane, w_lane_nxt;
    logic [7:0]        r_wbyte, w_wbyte_nxt;
    logic              w_tmr_clr, w_tmr_inc, w_tmr_exp;
    logic              w_sel_lane;
    logic [7:0]        w_sel_byte, w_rd_byte;
    logic [15:0]       w_src_word, w_merged;
`ifdef SRAM_BRIDGE_WORD_CACHE_EN
    logic              r_c_valid, w_c_valid_nxt;
    logic [MEM_AW-1:0] r_c_addr, w_c_addr_nxt;
    logic [15:0]       r_c_word, w_c_word_nxt;
    logic              w_c_hit;

    assign w_c_hit = r_c_valid && (r_c_addr == bus.cpu_addr[CPU_AW-1:1]);
`endif

    sram_req_timer #(.LIMIT(TIMEOUT_CYC), .W(tmr_width(TIMEOUT_CYC))) u_timer (
        .CLK0      (CLK0),
        .reset_n   (reset_n),
        .i_clr     (w_tmr_clr),
        .i_inc     (w_tmr_inc),
        .o_expired (w_tmr_exp)
    );

    // Byte lane source: in IDLE only the cache can supply a word, otherwise the SRAM read data.
    always_comb begin
        w_sel_lane = r_lane;
        w_sel_byte = r_wbyte;
        w_src_word = bus.mem_rdata;
`ifdef SRAM_BRIDGE_WORD_CACHE_EN
        if (r_state == ST_IDLE) begin
            w_sel_lane = bus.cpu_addr[0];
            w_sel_byte = bus.cpu_wdata;
            w_src_word = r_c_word;
        end
`endif
        w_merged  = w_src_word;
        w_rd_byte = w_src_word[7:0];
        unique case (w_sel_lane)
            LANE_LO: w_merged[7:0] = w_sel_byte;
            LANE_HI: begin
                w_merged[15:8] = w_sel_byte;
                w_rd_byte      = w_src_word[15:8];
            end
        endcase
    end

    always_ff @(posedge CLK0) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cpu_ready_nxt = r_cpu_ready;
        w_cpu_rdata_nxt = r_cpu_rdata;
        w_mem_rd_nxt    = r_mem_rd;
        w_mem_wr_nxt    = r_mem_wr;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_err_nxt       = r_err;
        w_lane_nxt      = r_lane;
        w_wbyte_nxt     = r_wbyte;
        w_tmr_clr       = 1'b0;
        w_tmr_inc       = 1'b0;
`ifdef SRAM_BRIDGE_WORD_CACHE_EN
        w_c_valid_nxt   = r_c_valid;
        w_c_addr_nxt    = r_c_addr;
        w_c_word_nxt    = r_c_word;
`endif
        if (bus.cpu_stb && (r_state != ST_IDLE)) w_err_nxt = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (bus.cpu_stb && (bus.cpu_wr || bus.cpu_rd)) begin
                    w_mem_addr_nxt  = bus.cpu_addr[CPU_AW-1:1];
                    w_lane_nxt      = bus.cpu_addr[0];
                    w_wbyte_nxt     = bus.cpu_wdata;
                    w_cpu_ready_nxt = 1'b0;
                    w_tmr_clr       = 1'b1;
                    w_mem_rd_nxt    = 1'b1;
                    w_state_nxt     = bus.cpu_wr ? ST_WR_FETCH : ST_RD;
`ifdef SRAM_BRIDGE_WORD_CACHE_EN
                    if (w_c_hit && bus.cpu_wr) begin
                        w_state_nxt     = ST_WR_STORE;
                        w_mem_rd_nxt    = 1'b0;
                        w_mem_wr_nxt    = 1'b1;
                        w_mem_wdata_nxt = w_merged;
                    end else if (w_c_hit) begin
                        w_state_nxt     = ST_IDLE;
                        w_mem_rd_nxt    = 1'b0;
                        w_cpu_ready_nxt = 1'b1;
                        w_cpu_rdata_nxt = w_rd_byte;
                    end
`endif
                end
            end
            ST_RD: begin
                if (bus.mem_ready) begin
                    w_cpu_rdata_nxt = w_rd_byte;
                    w_mem_rd_nxt    = 1'b0;
                    w_cpu_ready_nxt = 1'b1;
                    w_state_nxt     = ST_IDLE;
`ifdef SRAM_BRIDGE_WORD_CACHE_EN
                    w_c_valid_nxt   = 1'b1;
                    w_c_addr_nxt    = r_mem_addr;
                    w_c_word_nxt    = bus.mem_rdata;
`endif
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            ST_WR_FETCH: begin
                if (bus.mem_ready) begin
                    w_mem_wdata_nxt = w_merged;
                    w_mem_rd_nxt    = 1'b0;
                    w_mem_wr_nxt    = 1'b1;
                    w_tmr_clr       = 1'b1;
                    w_state_nxt     = ST_WR_STORE;
`ifdef SRAM_BRIDGE_WORD_CACHE_EN
                    w_c_valid_nxt   = 1'b1;
                    w_c_addr_nxt    = r_mem_addr;
                    w_c_word_nxt    = bus.mem_rdata;
`endif
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            ST_WR_STORE: begin
                if (bus.mem_ready) begin
                    w_mem_wr_nxt    = 1'b0;
                    w_cpu_ready_nxt = 1'b1;
                    w_state_nxt     = ST_IDLE;
`ifdef SRAM_BRIDGE_WORD_CACHE_EN
                    w_c_valid_nxt   = 1'b1;
                    w_c_addr_nxt    = r_mem_addr;
                    w_c_word_nxt    = r_mem_wdata;
`endif
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Abort overrides whatever the waiting state decided; the SRAM never sees a partial store.
        if (w_tmr_inc && w_tmr_exp) begin
            w_mem_rd_nxt    = 1'b0;
            w_mem_wr_nxt    = 1'b0;
            w_err_nxt       = 1'b1;
            w_cpu_ready_nxt = 1'b1;
            w_state_nxt     = ST_IDLE;
            if (r_state == ST_RD) w_cpu_rdata_nxt = RD_ERR_BYTE;
`ifdef SRAM_BRIDGE_WORD_CACHE_EN
            w_c_valid_nxt   = 1'b0;
`endif
        end
    end

    always_ff @(posedge CLK0) begin
        if (!reset_n) begin
            r_cpu_ready <= 1'b1;
            r_cpu_rdata <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_err       <= 1'b0;
            r_lane      <= LANE_LO;
            r_wbyte     <= '0;
`ifdef SRAM_BRIDGE_WORD_CACHE_EN
            r_c_valid   <= 1'b0;
            r_c_addr    <= '0;
            r_c_word    <= '0;
`endif
        end else begin
            r_cpu_ready <= w_cpu_ready_nxt;
            r_cpu_rdata <= w_cpu_rdata_nxt;
            r_mem_rd    <= w_mem_rd_nxt;
            r_mem_wr    <= w_mem_wr_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_err       <= w_err_nxt;
            r_lane      <= w_lane_nxt;
            r_wbyte     <= w_wbyte_nxt;
`ifdef SRAM_BRIDGE_WORD_CACHE_EN
            r_c_valid   <= w_c_valid_nxt;
            r_c_addr    <= w_c_addr_nxt;
            r_c_word    <= w_c_word_nxt;
`endif
        end
    end

    assign bus.cpu_ready = r_cpu_ready;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.mem_rd    = r_mem_rd;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_sram_byte_bridge.sv
// Directed bench for sram_byte_bridge: behavioural SRAM controller plus read/write scoreboards.
module tb_sram_byte_bridge;
    logic CLK0 = 1'b0;
    logic reset_n;
    always #5 CLK0 = ~CLK0;

    sram_byte_bridge_if bus ();

    sram_byte_bridge #(.CPU_AW(19), .MEM_AW(18), .TIMEOUT_CYC(15)) dut (
        .CLK0    (CLK0),
        .reset_n (reset_n),
        .bus     (bus)
    );

`ifdef SRAM_BRIDGE_WORD_CACHE_EN
    localparam bit HIT = 1'b1;
`else
    localparam bit HIT = 1'b0;
`endif

    logic [15:0] sram [0:255];
    int          lat = 1;
    bit          resp_rd_en = 1'b1;
    bit          resp_wr_en = 1'b1;
    int          n_rd_req = 0;
    bit          both_hi = 1'b0;
    bit          prev_rd = 1'b0;
    logic [15:0] last_wdata = '0;
    int          n_pass = 0, n_total = 0, n_fail = 0;
    logic [7:0]  rq [$];
    logic [15:0] wq [$];

    // SRAM controller model: answers a held request with a one-cycle mem_ready after lat cycles.
    initial begin
        int cnt;
        cnt = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge CLK0);
            if (bus.mem_rd && bus.mem_wr) both_hi = 1'b1;
            if (bus.mem_rd && !prev_rd) n_rd_req++;
            prev_rd = bus.mem_rd;
            if (bus.mem_ready) begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = 16'($urandom);
                cnt = 0;
            end else if ((bus.mem_rd && resp_rd_en) || (bus.mem_wr && resp_wr_en)) begin
                if (cnt >= lat) begin
                    bus.mem_ready = 1'b1;
                    cnt = 0;
                    if (bus.mem_rd) begin
                        bus.mem_rdata = sram[bus.mem_addr[7:0]];
                    end else begin
                        sram[bus.mem_addr[7:0]] = bus.mem_wdata;
                        last_wdata = bus.mem_wdata;
                    end
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.cpu_stb = 1'b0;
        bus.cpu_rd  = 1'b0;
        bus.cpu_wr  = 1'b0;
        repeat (2) @(negedge CLK0);
        reset_n = 1'b1;
    endtask

    task automatic strobe(input logic rd, input logic wr, input logic [18:0] a, input logic [7:0] d);
        bus.cpu_stb   = 1'b1;
        bus.cpu_rd    = rd;
        bus.cpu_wr    = wr;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        @(negedge CLK0);
        bus.cpu_stb = 1'b0;
        bus.cpu_rd  = 1'b0;
        bus.cpu_wr  = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit rdy_after);
        bit pr, got;
        cyc = 0;
        rdy_after = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge CLK0);
            pr = bus.mem_ready;
            @(negedge CLK0);
            cyc++;
            if (bus.cpu_ready) begin
                rdy_after = pr;
                got = 1'b1;
                break;
            end
        end
        chk("cpu_ready_within_bound", 32'(got), 1);
    endtask

    task automatic do_read(input logic [18:0] a, input logic [7:0] exp, input bit hit, output int cyc);
        bit pr;
        rq.push_back(exp);
        cyc = 0;
        strobe(1'b1, 1'b0, a, 8'h00);
        if (hit) begin
            chk("rd_hit_no_mem_rd", 32'(bus.mem_rd), 0);
            chk("rd_hit_ready_high", 32'(bus.cpu_ready), 1);
        end else begin
            chk("rd_mem_rd_issued", 32'(bus.mem_rd), 1);
            chk("rd_mem_addr", 32'(bus.mem_addr), 32'(a[18:1]));
            chk("rd_cpu_stalled", 32'(bus.cpu_ready), 0);
            wait_done(cyc, pr);
            chk("rd_ready_after_mem_ready", 32'(pr), 1);
        end
        chk("rd_cpu_rdata", 32'(bus.cpu_rdata), 32'(rq.pop_front()));
        chk("rd_mem_rd_dropped", 32'(bus.mem_rd), 0);
    endtask

    task automatic do_write(input logic [18:0] a, input logic [7:0] d, input bit fetch);
        logic [15:0] old, e;
        int cyc;
        bit pr;
        old = sram[a[8:1]];
        wq.push_back(a[0] ? {d, old[7:0]} : {old[15:8], d});
        strobe(1'b0, 1'b1, a, d);
        if (fetch) chk("wr_fetch_issued", 32'(bus.mem_rd), 1);
        else       chk("wr_hit_store_issued", 32'(bus.mem_wr), 1);
        chk("wr_mem_addr", 32'(bus.mem_addr), 32'(a[18:1]));
        chk("wr_cpu_stalled", 32'(bus.cpu_ready), 0);
        wait_done(cyc, pr);
        chk("wr_ready_after_mem_ready", 32'(pr), 1);
        chk("wr_mem_wr_dropped", 32'(bus.mem_wr), 0);
        e = wq.pop_front();
        chk("wr_sram_word", 32'(sram[a[8:1]]), 32'(e));
        chk("wr_mem_wdata", 32'(last_wdata), 32'(e));
    endtask

    initial begin
        int cyc, n, n0;
        bit pr, got;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        for (int i = 0; i < 256; i++) sram[i] = 16'(i * 16'h0101);
        do_reset();

        chk("rst_cpu_ready", 32'(bus.cpu_ready), 1);
        chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
        chk("rst_mem_rd", 32'(bus.mem_rd), 0);
        chk("rst_mem_wr", 32'(bus.mem_wr), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
        chk("rst_err", 32'(bus.err), 0);

        // Reads: odd lane, then even lane at minimum latency.
        sram[8'h10] = 16'hBEEF;
        sram[8'h11] = 16'h5A3C;
        lat = 1;
        do_read(19'h00021, 8'hBE, 1'b0, cyc);
        lat = 0;
        do_read(19'h00022, 8'h3C, 1'b0, cyc);
        chk("rd_min_latency", 32'(cyc), 1);

        // Byte write with read-modify-write, then readback of both lanes.
        lat = 1;
        do_write(19'h00020, 8'h12, !HIT);
        do_read(19'h00021, 8'hBE, HIT, cyc);
        do_read(19'h00020, 8'h12, HIT, cyc);
        chk("rd_wr_never_both_high", 32'(both_hi), 0);

        // Read timeout.
        resp_rd_en = 1'b0;
        rq.push_back(RD_ERR_BYTE_TB());
        strobe(1'b1, 1'b0, 19'h00004, 8'h00);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.mem_rd) break;
            n++;
            @(negedge CLK0);
        end
        chk("to_mem_rd_cycles", 32'(n), 15);
        chk("to_mem_rd_low", 32'(bus.mem_rd), 0);
        chk("to_cpu_ready", 32'(bus.cpu_ready), 1);
        chk("to_err", 32'(bus.err), 1);
        chk("to_rdata", 32'(bus.cpu_rdata), 32'(rq.pop_front()));
        resp_rd_en = 1'b1;
        do_read(19'h00021, 8'hBE, 1'b0, cyc);
        chk("err_sticky", 32'(bus.err), 1);

        // Write timeout in the store phase leaves the SRAM word alone.
        resp_wr_en = 1'b0;
        sram[8'h18] = 16'h1234;
        strobe(1'b0, 1'b1, 19'h00031, 8'hAA);
        wait_done(cyc, pr);
        chk("wto_mem_wr_low", 32'(bus.mem_wr), 0);
        chk("wto_sram_unchanged", 32'(sram[8'h18]), 32'h1234);
        resp_wr_en = 1'b1;
        do_write(19'h00031, 8'hAA, 1'b1);

        // Strobe overrun during a read.
        do_reset();
        chk("rst_err_cleared", 32'(bus.err), 0);
        sram[8'h10] = 16'hBEEF;
        lat = 3;
        n0 = n_rd_req;
        rq.push_back(8'hBE);
        strobe(1'b1, 1'b0, 19'h00021, 8'h00);
        strobe(1'b1, 1'b0, 19'h00040, 8'h00);
        chk("ovr_err", 32'(bus.err), 1);
        chk("ovr_mem_addr_stable", 32'(bus.mem_addr), 32'h10);
        wait_done(cyc, pr);
        chk("ovr_ready_after_mem_ready", 32'(pr), 1);
        chk("ovr_rdata", 32'(bus.cpu_rdata), 32'(rq.pop_front()));
        chk("ovr_single_request", 32'(n_rd_req - n0), 1);

        // Reset while waiting in the store phase.
        lat = 1;
        resp_wr_en = 1'b0;
        strobe(1'b0, 1'b1, 19'h00020, 8'h99);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_wr) begin
                got = 1'b1;
                break;
            end
            @(negedge CLK0);
        end
        chk("rstw_reached_store", 32'(got), 1);
        reset_n = 1'b0;
        @(negedge CLK0);
        chk("rstw_mem_wr", 32'(bus.mem_wr), 0);
        chk("rstw_mem_rd", 32'(bus.mem_rd), 0);
        chk("rstw_cpu_ready", 32'(bus.cpu_ready), 1);
        chk("rstw_err", 32'(bus.err), 0);
        reset_n = 1'b1;
        resp_wr_en = 1'b1;
        chk("rstw_sram_unchanged", 32'(sram[8'h10]), 32'hBEEF);

        // Two reads of one word, then a write to it.
        do_reset();
        n0 = n_rd_req;
        do_read(19'h00020, 8'hEF, 1'b0, cyc);
        do_read(19'h00021, 8'hBE, HIT, cyc);
        chk("pair_read_requests", 32'(n_rd_req - n0), HIT ? 1 : 2);
        do_write(19'h00020, 8'h77, !HIT);
        chk("pair_write_requests", 32'(n_rd_req - n0), HIT ? 1 : 3);
        chk("final_never_both_high", 32'(both_hi), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    function automatic logic [7:0] RD_ERR_BYTE_TB();
        return 8'hFF;
    endfunction
endmodule

// File: doc/sram_byte_bridge.md
Name: sram_byte_bridge

Overview:
Sits between the 65xx SoC external bus (8-bit data, 19-bit byte address) and the 16-bit SRAM controller.
- Maps the full 512 KB byte space onto 256K x16 SRAM words.
- Performs read-modify-write for byte stores, because the SRAM has no byte-lane enables.
- Stalls the CPU through its ready input while a memory transaction is in flight.
- Runs entirely in the CLK0 domain; the CPU side is sampled on a per-CPU-cycle strobe.

Parameters:
CPU_AW, 19, CPU byte address width
MEM_AW, 18, SRAM word address width (must equal CPU_AW-1)
TIMEOUT_CYC, 15, max CLK0 cycles to wait for mem_ready before abort (4-bit counter)

Ports:
CLK0  in  1  clock
reset_n  in  1  reset, synchronous, active-low; clock CLK0
cpu_stb  in  1  one-CLK0 pulse marking start of a CPU bus cycle; cpu_* sampled here
cpu_addr  in  19  byte address
cpu_wdata  in  8  write byte
cpu_rd  in  1  read request (active-high)
cpu_wr  in  1  write request (active-high)
cpu_rdata  out  8  read byte
cpu_ready  out  1  low = stall CPU
mem_addr  out  18  word address to SRAM controller
mem_wdata  out  16  word to write
mem_rd  out  1  read request, held until mem_ready
mem_wr  out  1  write request, held until mem_ready
mem_rdata  in  16  word read data, valid with mem_ready on reads
mem_ready  in  1  one-cycle completion pulse
err  out  1  sticky: timeout or strobe overrun

Behaviour:
- Reset values: cpu_ready=1, cpu_rdata=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, err=0, FSM=IDLE, timer=0. Reset mid-transaction drops the request; mem_rd/mem_wr are low on the first cycle after reset.
- Lane mapping: mem_addr=cpu_addr[18:1]. cpu_addr[0]=0 selects [7:0]; cpu_addr[0]=1 selects [15:8].
- Request decode:
  - cpu_stb in IDLE with cpu_wr=1 starts a write; write wins if cpu_rd is also 1.
  - cpu_stb in IDLE with cpu_rd=1 only starts a read.
  - cpu_stb with neither set is a no-op.
  - cpu_stb outside IDLE is ignored and sets err.
- FSM states: IDLE, RD, WR_FETCH, WR_STORE.
  - IDLE:
    - Read accepted → RD; cpu_ready=0 and mem_rd=1 from the next cycle.
    - Write accepted → WR_FETCH; cpu_ready=0 and mem_rd=1.
  - RD: on mem_ready, capture the selected byte into cpu_rdata, drop mem_rd, set cpu_ready=1 and return to IDLE. Minimum read latency is strobe + 2 cycles when mem_ready arrives one cycle after the request.
  - WR_FETCH: on mem_ready, merge cpu_wdata into mem_rdata at the selected lane and put the result on mem_wdata. Drop mem_rd; raise mem_wr next cycle → WR_STORE.
  - WR_STORE: on mem_ready, drop mem_wr, set cpu_ready=1 → IDLE.
- Requests are level-held: mem_addr is stable and mem_rd and mem_wr are never both high.
- Timeout:
  - The timer clears on entry to each waiting state and increments each cycle mem_ready=0.
  - At TIMEOUT_CYC: drop mem_rd/mem_wr, set err, cpu_rdata=8'hFF on reads, cpu_ready=1 → IDLE. A write abort leaves the SRAM unmodified.
- mem_ready seen in IDLE is ignored.
- err is cleared only by reset.

Optional Feature:
Macro SRAM_BRIDGE_WORD_CACHE_EN.
- With it: a one-entry cache holds word, word address and valid bit.
  - valid is set by every completed read or fetch and updated by every completed store (write-through).
  - Read hit: returns the byte with cpu_ready held high and no mem_rd.
  - Write hit: skips WR_FETCH and goes directly to WR_STORE using the merged cached word.
  - Reset and any timeout clear valid.
- Without it: every access goes to SRAM exactly as described in Behaviour.

Decomposition:
- Package sram_bridge_pkg holds:
  - the FSM state enum;
  - LANE_LO/LANE_HI constants;
  - the RD_ERR_BYTE (8'hFF) constant;
  - the timer width, derived as $clog2(TIMEOUT_CYC+1).
- One sub-module, sram_req_timer: a clearable saturating counter with an expired flag.
- The byte merge stays inline.

Test Plan:
- Read odd byte: SRAM word 0x00010=16'hBEEF; stb, rd, addr 19'h00021 → mem_rd at 18'h00010, then cpu_rdata=8'hBE, cpu_ready rises the cycle after mem_ready.
- Byte write: word 0x00010=16'hBEEF; stb, wr, addr 19'h00020, wdata 8'h12 → fetch, then mem_wr with mem_wdata=16'hBE12; readback addr 19'h00021 returns 8'hBE.
- Timeout: mem_ready held low on a read → after 15 cycles mem_rd=0, cpu_rdata=8'hFF, err=1, cpu_ready=1; a following access works normally.
- Overrun: second cpu_stb during RD → ignored, err=1, first read completes correctly.
- Reset mid-write in WR_STORE → mem_wr=0 and cpu_ready=1 the next cycle, err=0.
- With SRAM_BRIDGE_WORD_CACHE_EN: two consecutive reads of 19'h00020/19'h00021 → only one mem_rd; the write hit issues no fetch.
